// File: rtl/jam_cost_table_pkg.sv
// Shared sizes, state encoding and helpers for the job-assignment cost table.
package jam_cost_table_pkg;

  localparam int N     = 8;        // workers = jobs
  localparam int IW    = 3;        // worker/job index width
  localparam int CW    = 7;        // cost entry width
  localparam int DEPTH = N * N;    // matrix entries
  localparam int AW    = 2 * IW;   // matrix address width, {W, J}
  localparam int RW    = 10;       // engine MinCost width
  localparam int MW    = 4;        // engine MatchCount width
  localparam int PCW   = 16;       // permutation group counter width

  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/jam_perm_checker.sv
// Watches the engine's worker/job lookups and verifies that every group of
// eight lookups visits each job exactly once.
module jam_perm_checker
  import jam_cost_table_pkg::*;
(
  input  logic           CLK,
  input  logic           RST,
  input  logic           en_i,
  input  logic [IW-1:0]  w_i,
  input  logic [IW-1:0]  j_i,
  output logic           perm_err_o,
  output logic [PCW-1:0] perm_cnt_o
);

  logic [IW-1:0]  w_prev_q, w_prev_d;
  logic [N-1:0]   mask_q, mask_d;
  logic           grp_err_q, grp_err_d;
  logic           perm_err_q, perm_err_d;
  logic [PCW-1:0] perm_cnt_q, perm_cnt_d;

  logic lookup;
  logic new_grp;

  // A lookup is a change of worker; the engine parks W during sort/swap phases.
  assign lookup  = en_i && (w_i != w_prev_q);
  assign new_grp = (w_i == '0) && (w_prev_q == IDX_LAST);

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path
    // through this block leaves it unassigned, which would infer a latch.
    w_prev_d   = w_prev_q;
    mask_d     = mask_q;
    grp_err_d  = grp_err_q;
    perm_err_d = perm_err_q;
    perm_cnt_d = perm_cnt_q;

    if (en_i) begin
      w_prev_d = w_i;
    end

    if (lookup) begin
      if (new_grp) begin
        mask_d    = onehot(j_i);
        grp_err_d = 1'b0;
      end else begin
        if (mask_q[j_i]) begin
          perm_err_d = 1'b1;
          grp_err_d  = 1'b1;
        end
        mask_d = mask_q | onehot(j_i);
      end

      if ((w_i == IDX_LAST) && (mask_d == '1) && !grp_err_d &&
          (perm_cnt_q != '1)) begin
        perm_cnt_d = perm_cnt_q + PCW'(1);
      end
    end
  end

  // The first group's W=0,J=0 lookup is implied by the reset mask.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (RST) begin
      w_prev_q   <= '0;
      mask_q     <= {{(N-1){1'b0}}, 1'b1};
      grp_err_q  <= 1'b0;
      perm_err_q <= 1'b0;
      perm_cnt_q <= '0;
    end else begin
      w_prev_q   <= w_prev_d;
      mask_q     <= mask_d;
      grp_err_q  <= grp_err_d;
      perm_err_q <= perm_err_d;
      perm_cnt_q <= perm_cnt_d;
    end
  end

  assign perm_err_o = perm_err_q;
  assign perm_cnt_o = perm_cnt_q;

endmodule

// File: rtl/jam_cost_table.sv
// 8x8 cost matrix for the job-assignment engine: streamed in once, then read
// combinationally, with lookup legality checking and result capture.
module jam_cost_table
  import jam_cost_table_pkg::*;
(
  input  logic           CLK,
  input  logic           RST,
  input  logic           ld_valid,
  input  logic [CW-1:0]  ld_data,
  output logic           ld_ready,
  output logic           loaded,
  input  logic [IW-1:0]  W,
  input  logic [IW-1:0]  J,
  output logic [CW-1:0]  Cost,
  input  logic           Valid,
  input  logic [RW-1:0]  MinCost,
  input  logic [MW-1:0]  MatchCount,
  output logic           perm_err,
  output logic [PCW-1:0] perm_cnt,
  output logic           done,
  output logic [RW-1:0]  res_min,
  output logic [MW-1:0]  res_cnt
);

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic          ld_ready_q;
  logic          loaded_q;
  logic          done_q;
  logic [RW-1:0] res_min_q;
  logic [MW-1:0] res_cnt_q;
  logic [CW-1:0] mem_q [DEPTH];

  logic wr_en;

  assign wr_en = (state_q == ST_LOAD) && ld_valid && ld_ready_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_LOAD;
      addr_q     <= '0;
      ld_ready_q <= 1'b1;
      loaded_q   <= 1'b0;
      done_q     <= 1'b0;
      res_min_q  <= '0;
      res_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          if (wr_en) begin
            addr_q <= addr_q + AW'(1);
            if (addr_q == AW'(DEPTH - 1)) begin
              state_q    <= ST_SERVE;
              ld_ready_q <= 1'b0;
              loaded_q   <= 1'b1;
            end
          end
        end
        ST_SERVE: begin
          if (Valid) begin
            res_min_q <= MinCost;
            res_cnt_q <= MatchCount;
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_LOAD;
        end
      endcase
    end
  end

  // Matrix is row-major: address {W, J}, written in stream order.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: this array is deliberately reset, because a partial load must
    // read back zeros for entries not yet written; that rules out RAM macros.
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[addr_q] <= ld_data;
    end
  end

  assign Cost = mem_q[{W, J}];

  jam_perm_checker u_perm_checker (
    .CLK        (CLK),
    .RST        (RST),
    .en_i       (state_q == ST_SERVE),
    .w_i        (W),
    .j_i        (J),
    .perm_err_o (perm_err),
    .perm_cnt_o (perm_cnt)
  );

  assign ld_ready = ld_ready_q;
  assign loaded   = loaded_q;
  assign done     = done_q;
  assign res_min  = res_min_q;
  assign res_cnt  = res_cnt_q;

endmodule

// File: tb/tb_jam_cost_table.sv
// Self-checking bench for jam_cost_table against a behavioural model built
// from arrays and a queue of jobs seen in the current permutation group.
module tb_jam_cost_table;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ld_valid;
  logic [6:0]  ld_data;
  logic        ld_ready;
  logic        loaded;
  logic [2:0]  W;
  logic [2:0]  J;
  logic [6:0]  Cost;
  logic        Valid;
  logic [9:0]  MinCost;
  logic [3:0]  MatchCount;
  logic        perm_err;
  logic [15:0] perm_cnt;
  logic        done;
  logic [9:0]  res_min;
  logic [3:0]  res_cnt;

  jam_cost_table dut (
    .CLK        (CLK),
    .RST        (RST),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .loaded     (loaded),
    .W          (W),
    .J          (J),
    .Cost       (Cost),
    .Valid      (Valid),
    .MinCost    (MinCost),
    .MatchCount (MatchCount),
    .perm_err   (perm_err),
    .perm_cnt   (perm_cnt),
    .done       (done),
    .res_min    (res_min),
    .res_cnt    (res_cnt)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 = loading, 1 = serving, 2 = result captured.
  int m_mem [64];
  int m_addr;
  int m_phase;
  int m_err;
  int m_cnt;
  int m_done;
  int m_rmin;
  int m_rcnt;
  int m_prevw;
  int grp [$];
  bit m_gerr;
  int best_perm [8];

  task automatic model_reset();
    foreach (m_mem[i]) m_mem[i] = 0;
    m_addr  = 0;
    m_phase = 0;
    m_err   = 0;
    m_cnt   = 0;
    m_done  = 0;
    m_rmin  = 0;
    m_rcnt  = 0;
    m_prevw = 0;
    grp     = {0};
    m_gerr  = 1'b0;
  endtask

  function automatic bit in_grp(input int j);
    foreach (grp[i]) if (grp[i] == j) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    int w, j;
    w = int'(W);
    j = int'(J);
    if (m_phase == 0) begin
      if (ld_valid) begin
        m_mem[m_addr] = int'(ld_data);
        if (m_addr == 63) m_phase = 1;
        else m_addr++;
      end
    end else if (m_phase == 1) begin
      if (w != m_prevw) begin
        if (w == 0 && m_prevw == 7) begin
          grp    = {j};
          m_gerr = 1'b0;
        end else if (in_grp(j)) begin
          m_err  = 1;
          m_gerr = 1'b1;
        end else begin
          grp.push_back(j);
        end
        if (w == 7 && grp.size() == 8 && !m_gerr && m_cnt < 65535) m_cnt++;
      end
      m_prevw = w;
      if (Valid) begin
        m_rmin  = int'(MinCost);
        m_rcnt  = int'(MatchCount);
        m_done  = 1;
        m_phase = 2;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".ld_ready"}, ld_ready, m_phase == 0);
    check({tag, ".loaded"},   loaded,   m_phase != 0);
    check({tag, ".cost"},     Cost,     m_mem[int'(W) * 8 + int'(J)]);
    check({tag, ".perm_err"}, perm_err, m_err);
    check({tag, ".perm_cnt"}, perm_cnt, m_cnt);
    check({tag, ".done"},     done,     m_done);
    check({tag, ".res_min"},  res_min,  m_rmin);
    check({tag, ".res_cnt"},  res_cnt,  m_rcnt);
  endtask

  // Exhaustive search over all 8! assignments of the model matrix.
  task automatic find_best(output int best);
    int p [8];
    int i, j, t, s;
    bit more;
    more = 1'b1;
    best = 1 << 30;
    for (int k = 0; k < 8; k++) p[k] = k;
    while (more) begin
      s = 0;
      for (int k = 0; k < 8; k++) s += m_mem[k * 8 + p[k]];
      if (s < best) begin
        best = s;
        for (int k = 0; k < 8; k++) best_perm[k] = p[k];
      end
      i = 6;
      while (i >= 0 && p[i] > p[i+1]) i--;
      if (i < 0) begin
        more = 1'b0;
      end else begin
        j = 7;
        while (p[j] < p[i]) j--;
        t = p[i]; p[i] = p[j]; p[j] = t;
        for (int a = i + 1, b = 7; a < b; a++, b--) begin
          t = p[a]; p[a] = p[b]; p[b] = t;
        end
      end
    end
  endtask

  task automatic drive_group(input string tag, input int js [8]);
    for (int w = 0; w < 8; w++) begin
      W = 3'(w);
      J = 3'(js[w]);
      #1;
      check_outputs(tag);
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int accepts, cyc, golden, sum_a, sum_b, engine_min;
    int perm [8];
    int id_perm [8];
    int swap_perm [8];
    int dup_perm [8];

    id_perm   = '{0, 1, 2, 3, 4, 5, 6, 7};
    swap_perm = '{0, 1, 2, 3, 4, 5, 7, 6};
    dup_perm  = '{0, 1, 2, 2, 4, 5, 6, 7};

    RST = 1'b1; ld_valid = 1'b0; ld_data = '0; W = '0; J = '0;
    Valid = 1'b0; MinCost = '0; MatchCount = '0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Load standard matrix with ld_valid held high; Cost trails the write.
    accepts = 0;
    cyc     = 0;
    ld_valid = 1'b1;
    while (ld_ready === 1'b1 && cyc < 100) begin
      ld_data = 7'(accepts % 128);
      if (accepts > 0) begin
        W = 3'((accepts - 1) / 8);
        J = 3'((accepts - 1) % 8);
      end
      #1;
      check_outputs("load");
      tick();
      accepts++;
      cyc++;
    end
    check("load.accepts", accepts, 64);
    ld_valid = 1'b0;
    W = '0;
    J = '0;
    #1;
    check_outputs("loaded");

    // Directed permutation groups.
    for (int w = 1; w < 8; w++) begin
      W = 3'(w);
      J = 3'(w);
      #1;
      check_outputs("perm_id");
      tick();
    end
    drive_group("perm_swap", swap_perm);
    check("perm_two.cnt", perm_cnt, 2);
    check("perm_two.err", perm_err, 0);
    drive_group("perm_dup", dup_perm);
    check("perm_dup.err", perm_err, 1);
    check("perm_dup.cnt", perm_cnt, 2);
    drive_group("perm_after", id_perm);
    check("perm_after.err", perm_err, 1);

    // Random engine traffic with parked W and occasional illegal groups.
    for (int g = 0; g < 30; g++) begin
      int r, t, hold;
      for (int k = 0; k < 8; k++) perm[k] = k;
      for (int k = 7; k > 0; k--) begin
        r = $urandom_range(k, 0);
        t = perm[k]; perm[k] = perm[r]; perm[r] = t;
      end
      if ($urandom_range(3, 0) == 0) perm[$urandom_range(7, 0)] = $urandom_range(7, 0);
      for (int w = 0; w < 8; w++) begin
        W = 3'(w);
        J = 3'(perm[w]);
        hold = $urandom_range(2, 0);
        for (int h = 0; h <= hold; h++) begin
          if (h > 0) J = 3'($urandom_range(7, 0));
          #1;
          check_outputs("rand");
          tick();
        end
      end
    end

    // Result capture coincident with a lookup, then a second strobe ignored.
    W = '0; J = '0;
    Valid = 1'b1; MinCost = 10'd215; MatchCount = 4'd3;
    tick();
    Valid = 1'b0;
    #1;
    check("valid.done", done, 1);
    check("valid.res_min", res_min, 215);
    check("valid.res_cnt", res_cnt, 3);
    check_outputs("valid");
    Valid = 1'b1; MinCost = 10'd500; MatchCount = 4'd9;
    tick();
    Valid = 1'b0;
    #1;
    check("valid2.res_min", res_min, 215);
    check("valid2.res_cnt", res_cnt, 3);

    // DONE: lookups and loads have no effect.
    ld_valid = 1'b1;
    ld_data  = '0;
    for (int w = 1; w < 8; w++) begin
      W = 3'(w);
      J = 3'(w);
      #1;
      check_outputs("done_idle");
      tick();
    end
    ld_valid = 1'b0;
    W = 3'd3; J = 3'd5;
    #1;
    check("spot.cost_3_5", Cost, 29);
    W = 3'd7; J = 3'd7;
    #1;
    check("spot.cost_7_7", Cost, 63);

    // Reset, partial load, then reset mid-load.
    W = '0; J = '0;
    RST = 1'b1;
    #1;
    model_reset();
    check_outputs("rst_serve");
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    ld_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      ld_data = 7'($urandom_range(127, 1));
      #1;
      check_outputs("part_load");
      tick();
    end
    ld_valid = 1'b0;
    W = 3'd1; J = 3'd2;
    #1;
    check_outputs("part_load_rd");
    RST = 1'b1;
    #2;
    model_reset();
    check("rst_mid.cost_1_2", Cost, 0);
    check("rst_mid.ld_ready", ld_ready, 1);
    check("rst_mid.loaded", loaded, 0);
    W = '0; J = '0;
    #1;
    check("rst_mid.cost_0_0", Cost, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Reload with ld_valid toggling and random entries.
    accepts = 0;
    cyc     = 0;
    while (m_phase == 0 && cyc < 200) begin
      ld_valid = (cyc % 2 == 0);
      ld_data  = 7'($urandom_range(127, 0));
      #1;
      if (ld_valid && ld_ready) accepts++;
      check_outputs("reload");
      tick();
      cyc++;
    end
    ld_valid = 1'b0;
    check("reload.accepts", accepts, 64);
    check("reload.cycles", cyc, 127);
    check("reload.loaded", loaded, 1);

    for (int a = 0; a < 64; a++) begin
      W = 3'(a / 8);
      J = 3'(a % 8);
      #1;
      check("sweep.cost", Cost, m_mem[a]);
      tick();
    end

    // Engine run: try identity and the optimum, report the lower total.
    find_best(golden);
    sum_a = 0;
    sum_b = 0;
    for (int w = 0; w < 8; w++) begin
      W = 3'(w); J = 3'(w);
      #1;
      sum_a += int'(Cost);
      check_outputs("engine_id");
      tick();
    end
    for (int w = 0; w < 8; w++) begin
      W = 3'(w); J = 3'(best_perm[w]);
      #1;
      sum_b += int'(Cost);
      check_outputs("engine_best");
      tick();
    end
    engine_min = (sum_a < sum_b) ? sum_a : sum_b;
    Valid = 1'b1; MinCost = 10'(engine_min); MatchCount = 4'd8;
    tick();
    Valid = 1'b0;
    #1;
    check("engine.done", done, 1);
    check("engine.res_min", res_min, golden);
    check("engine.res_cnt", res_cnt, 8);
    check_outputs("engine_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
